ext_dbg_bus_eng: RTL and testbench

//  cp2-domain engine behind the JTAG debug chains. Executes single or burst read/write accesses
//  to I/O or data RAM space from AC/D chain updates, with auto-increment, wait handling,
//  a wait-timeout abort, and sticky error/overflow status. Feeds the AC/D chain capture inputs.

---
 rtl/ext_dbg_bus_eng_if.sv | 32 +++
 rtl/ext_dbg_bus_eng.sv | 180 ++++++++++++++++++
 tb/tb_ext_dbg_bus_eng.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_dbg_bus_eng_if.sv
// Debug engine side of the I/O and data-RAM buses. The engine drives the
// strobes, addresses and write data; the memory side returns read data and wait.
interface ext_dbg_bus_eng_if #(
   parameter int ADR_W    = 16,
   parameter int IO_ADR_W = 6,
   parameter int DW       = 8
);
   logic [IO_ADR_W-1:0] d_adr;
   logic                d_iore;
   logic                d_iowe;
   logic                d_iowait;
   logic [DW-1:0]       d_io_dbusout;
   logic [DW-1:0]       d_io_dbusin;
   logic [ADR_W-1:0]    d_ramadr;
   logic                d_ramre;
   logic                d_ramwe;
   logic                d_ramwait;
   logic [DW-1:0]       d_dm_dbusout;
   logic [DW-1:0]       d_dm_dbusin;

   modport master (
      output d_adr, d_iore, d_iowe, d_io_dbusout,
      output d_ramadr, d_ramre, d_ramwe, d_dm_dbusout,
      input  d_iowait, d_io_dbusin, d_ramwait, d_dm_dbusin
   );

   modport slave (
      input  d_adr, d_iore, d_iowe, d_io_dbusout,
      input  d_ramadr, d_ramre, d_ramwe, d_dm_dbusout,
      output d_iowait, d_io_dbusin, d_ramwait, d_dm_dbusin
   );
endinterface

// File: rtl/ext_dbg_bus_eng.sv
// cp2-side engine for the JTAG AC/D debug chains: single/burst I/O or RAM
// accesses with auto-increment, wait handling, wait timeout and sticky status.
module ext_dbg_bus_eng #(
   parameter int ADR_W    = 16,
   parameter int IO_ADR_W = 6,
   parameter int DW       = 8,
   parameter int BURST_W  = 4,
   parameter int TO_W     = 8,
   localparam int AC_W    = ADR_W + BURST_W + 3
) (
   input  logic                cp2,
   input  logic                ireset,
   input  logic [AC_W-1:0]     j_ac_in,
   input  logic [DW-1:0]       j_d_in,
   input  logic                j_upd_ac,
   input  logic                j_upd_d,
   input  logic                tlr_st,
   output logic [AC_W-1:0]     j_ac_out,
   output logic [DW:0]         j_d_out,
   ext_dbg_bus_eng_if.master   bus
);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   // Abort fires on the wait cycle that would bring the count to 2^TO_W-1.
   localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   state_t               state_q, state_d;
   logic                 upd_ac_q, upd_d_q;
   logic                 wr_q, wr_d;
   logic                 io_q, io_d;
   logic                 inc_q, inc_d;
   logic [ADR_W-1:0]     cur_adr_q, cur_adr_d;
   logic [BURST_W-1:0]   remaining_q, remaining_d;
   logic                 busy_q, busy_d;
   logic                 to_err_q, to_err_d;
   logic                 ovf_q, ovf_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [DW-1:0]        rdata_q, rdata_d;
   logic [DW-1:0]        wdata_q, wdata_d;
   logic [TO_W-1:0]      wcnt_q, wcnt_d;

   logic                 ac_e, d_e, sel_wait, acc;
   logic [ADR_W-1:0]     adr_step;

   assign ac_e     = j_upd_ac & ~upd_ac_q;
   assign d_e      = j_upd_d & ~upd_d_q;
   assign sel_wait = io_q ? bus.d_iowait : bus.d_ramwait;

   // I/O bursts wrap inside the I/O window; RAM bursts wrap across the full space.
   assign adr_step = io_q
      ? {cur_adr_q[ADR_W-1:IO_ADR_W], cur_adr_q[IO_ADR_W-1:0] + IO_ADR_W'(inc_q)}
      : cur_adr_q + ADR_W'(inc_q);

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      io_d        = io_q;
      inc_d       = inc_q;
      cur_adr_d   = cur_adr_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      to_err_d    = to_err_q;
      ovf_d       = ovf_q;
      rd_valid_d  = rd_valid_q;
      rdata_d     = rdata_q;
      wdata_d     = wdata_q;
      wcnt_d      = wcnt_q;

      if (tlr_st) begin
         state_d    = IDLE;
         busy_d     = 1'b0;
         to_err_d   = 1'b0;
         ovf_d      = 1'b0;
         rd_valid_d = 1'b0;
         wcnt_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ac_e) begin
                  wr_d        = j_ac_in[AC_W-1];
                  io_d        = j_ac_in[AC_W-2];
                  inc_d       = j_ac_in[AC_W-3];
                  remaining_d = j_ac_in[ADR_W+BURST_W-1:ADR_W];
                  cur_adr_d   = j_ac_in[ADR_W-1:0];
                  busy_d      = 1'b1;
                  rd_valid_d  = 1'b0;
                  to_err_d    = 1'b0;
                  ovf_d       = 1'b0;
                  wcnt_d      = '0;
                  state_d     = j_ac_in[AC_W-1] ? HOLD : ACC;
               end
            end
            HOLD: begin
               if (ac_e) ovf_d = 1'b1;
               if (d_e) begin
                  if (wr_q) wdata_d    = j_d_in;
                  else      rd_valid_d = 1'b0;
                  wcnt_d  = '0;
                  state_d = ACC;
               end
            end
            ACC: begin
               if (ac_e || d_e) ovf_d = 1'b1;
               if (!sel_wait) begin
                  if (!wr_q) begin
                     rdata_d    = io_q ? bus.d_io_dbusin : bus.d_dm_dbusin;
                     rd_valid_d = 1'b1;
                  end
                  if (remaining_q == '0) begin
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end else begin
                     remaining_d = remaining_q - 1'b1;
                     cur_adr_d   = adr_step;
                     state_d     = HOLD;
                  end
               end else if (wcnt_q == TO_LAST) begin
                  to_err_d = 1'b1;
                  busy_d   = 1'b0;
                  state_d  = IDLE;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset) begin
         state_q     <= IDLE;
         upd_ac_q    <= 1'b0;
         upd_d_q     <= 1'b0;
         wr_q        <= 1'b0;
         io_q        <= 1'b0;
         inc_q       <= 1'b0;
         cur_adr_q   <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         to_err_q    <= 1'b0;
         ovf_q       <= 1'b0;
         rd_valid_q  <= 1'b0;
         rdata_q     <= '0;
         wdata_q     <= '0;
         wcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         upd_ac_q    <= j_upd_ac;
         upd_d_q     <= j_upd_d;
         wr_q        <= wr_d;
         io_q        <= io_d;
         inc_q       <= inc_d;
         cur_adr_q   <= cur_adr_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         to_err_q    <= to_err_d;
         ovf_q       <= ovf_d;
         rd_valid_q  <= rd_valid_d;
         rdata_q     <= rdata_d;
         wdata_q     <= wdata_d;
         wcnt_q      <= wcnt_d;
      end
   end

   assign acc              = (state_q == ACC);
   assign bus.d_iore       = acc &  io_q & ~wr_q;
   assign bus.d_iowe       = acc &  io_q &  wr_q;
   assign bus.d_ramre      = acc & ~io_q & ~wr_q;
   assign bus.d_ramwe      = acc & ~io_q &  wr_q;
   assign bus.d_adr        = cur_adr_q[IO_ADR_W-1:0];
   assign bus.d_ramadr     = cur_adr_q;
   assign bus.d_io_dbusout = bus.d_iowe  ? wdata_q : '0;
   assign bus.d_dm_dbusout = bus.d_ramwe ? wdata_q : '0;

   assign j_ac_out = {busy_q, to_err_q, ovf_q, remaining_q, cur_adr_q};
   assign j_d_out  = {rd_valid_q, rdata_q};

endmodule

// File: tb/tb_ext_dbg_bus_eng.sv
// Scoreboard bench for ext_dbg_bus_eng: expected bus accesses are queued when
// a command is issued and retired by a monitor as each access completes.
module tb_ext_dbg_bus_eng;

   localparam int ADR_W = 16, IO_ADR_W = 6, DW = 8, BURST_W = 4, TO_W = 4;
   localparam int AC_W  = ADR_W + BURST_W + 3;

   typedef struct {
      logic        io;
      logic        wr;
      logic [15:0] adr;
      logic [7:0]  data;
   } acc_t;

   logic              cp2 = 1'b0;
   logic              ireset = 1'b0;
   logic [AC_W-1:0]   j_ac_in = '0;
   logic [DW-1:0]     j_d_in = '0;
   logic              j_upd_ac = 1'b0, j_upd_d = 1'b0, tlr_st = 1'b0;
   logic [AC_W-1:0]   j_ac_out;
   logic [DW:0]       j_d_out;

   ext_dbg_bus_eng_if #(.ADR_W(ADR_W), .IO_ADR_W(IO_ADR_W), .DW(DW)) bus ();

   ext_dbg_bus_eng #(
      .ADR_W(ADR_W), .IO_ADR_W(IO_ADR_W), .DW(DW), .BURST_W(BURST_W), .TO_W(TO_W)
   ) dut (
      .cp2(cp2), .ireset(ireset), .j_ac_in(j_ac_in), .j_d_in(j_d_in),
      .j_upd_ac(j_upd_ac), .j_upd_d(j_upd_d), .tlr_st(tlr_st),
      .j_ac_out(j_ac_out), .j_d_out(j_d_out), .bus(bus)
   );

   always #5 cp2 = ~cp2;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   strobe_total = 0;
   acc_t sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
      end
   endtask

   // Monitor: one strobe at a time, retire accesses on the completing cycle.
   int   mon_ns;
   logic mon_done, mon_io;
   acc_t mon_e;
   always @(negedge cp2) begin
      mon_ns = int'(bus.d_iore) + int'(bus.d_iowe) + int'(bus.d_ramre) + int'(bus.d_ramwe);
      if (mon_ns != 0) begin
         strobe_total <= strobe_total + 1;
         check_eq("one_strobe", mon_ns, 1);
         mon_io   = bus.d_iore | bus.d_iowe;
         mon_done = mon_io ? !bus.d_iowait : !bus.d_ramwait;
         if (mon_done) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               check_eq("acc_space", 32'(mon_io), 32'(mon_e.io));
               check_eq("acc_wr", 32'(bus.d_iowe | bus.d_ramwe), 32'(mon_e.wr));
               if (mon_io) check_eq("io_adr", 32'(bus.d_adr), 32'(mon_e.adr[IO_ADR_W-1:0]));
               else        check_eq("ram_adr", 32'(bus.d_ramadr), 32'(mon_e.adr));
               if (mon_e.wr)
                  check_eq("wr_data", 32'(mon_io ? bus.d_io_dbusout : bus.d_dm_dbusout),
                           32'(mon_e.data));
               $display("access io=%0d wr=%0d adr=0x%0h data=0x%0h", mon_e.io, mon_e.wr,
                        mon_e.adr, mon_e.data);
            end
         end
      end else begin
         check_eq("dbus_idle", 32'({bus.d_io_dbusout, bus.d_dm_dbusout}), 0);
      end
   end

   function automatic logic [AC_W-1:0] ac_word(input logic wr, input logic io, input logic inc,
                                               input logic [3:0] blen, input logic [15:0] adr);
      return {wr, io, inc, blen, adr};
   endfunction

   task automatic push_exp(input logic io, input logic wr, input logic [15:0] adr,
                           input logic [7:0] data);
      acc_t e;
      e.io = io; e.wr = wr; e.adr = adr; e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic pulse_ac(input logic [AC_W-1:0] ac);
      @(negedge cp2);
      j_ac_in  = ac;
      j_upd_ac = 1'b1;
      @(negedge cp2);
      j_upd_ac = 1'b0;
   endtask

   task automatic pulse_d(input logic [7:0] data);
      @(negedge cp2);
      j_d_in  = data;
      j_upd_d = 1'b1;
      @(negedge cp2);
      j_upd_d = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (j_ac_out[AC_W-1] && n < budget) begin
         @(negedge cp2);
         n++;
      end
      check_eq(tag, 32'(j_ac_out[AC_W-1]), 0);
      @(negedge cp2);
      #1;
   endtask

   int s0;

   initial begin
      bus.d_iowait = 1'b0; bus.d_ramwait = 1'b0;
      bus.d_io_dbusin = '0; bus.d_dm_dbusin = '0;
      repeat (3) @(negedge cp2);
      check_eq("rst_ac_out", 32'(j_ac_out), 0);
      check_eq("rst_d_out", 32'(j_d_out), 0);
      check_eq("rst_strobes", 32'({bus.d_iore, bus.d_iowe, bus.d_ramre, bus.d_ramwe}), 0);
      ireset = 1'b1;
      repeat (2) @(negedge cp2);
      #1;

      // Single I/O read
      s0 = strobe_total;
      bus.d_io_dbusin = 8'h5A;
      push_exp(1, 0, 16'h0021, 8'h00);
      pulse_ac(ac_word(0, 1, 0, 4'd0, 16'h0021));
      wait_idle("io_rd_idle", 20);
      check_eq("io_rd_dout", 32'(j_d_out), 32'h15A);
      check_eq("io_rd_acout", 32'(j_ac_out), 32'h0021);
      check_eq("io_rd_strobes", strobe_total - s0, 1);

      // RAM write burst of four beats
      s0 = strobe_total;
      pulse_ac(ac_word(1, 0, 1, 4'd3, 16'h0100));
      for (int i = 0; i < 4; i++) begin
         push_exp(0, 1, 16'h0100 + 16'(i), 8'(8'h11 * (i + 1)));
         pulse_d(8'(8'h11 * (i + 1)));
         repeat (2) @(negedge cp2);
      end
      wait_idle("burst_idle", 20);
      check_eq("burst_acout", 32'(j_ac_out), 32'h0103);
      check_eq("burst_strobes", strobe_total - s0, 4);

      // I/O wrap 0x3F -> 0x00
      bus.d_io_dbusin = 8'h77;
      push_exp(1, 0, 16'h003F, 8'h00);
      push_exp(1, 0, 16'h0000, 8'h00);
      pulse_ac(ac_word(0, 1, 1, 4'd1, 16'h003F));
      repeat (2) @(negedge cp2);
      pulse_d(8'h00);
      wait_idle("io_wrap_idle", 20);
      check_eq("io_wrap_dout", 32'(j_d_out), 32'h177);

      // RAM wrap 0xFFFF -> 0x0000
      bus.d_dm_dbusin = 8'hA5;
      push_exp(0, 0, 16'hFFFF, 8'h00);
      push_exp(0, 0, 16'h0000, 8'h00);
      pulse_ac(ac_word(0, 0, 1, 4'd1, 16'hFFFF));
      repeat (2) @(negedge cp2);
      pulse_d(8'h00);
      wait_idle("ram_wrap_idle", 20);
      check_eq("ram_wrap_acout", 32'(j_ac_out), 32'h0000);
      check_eq("ram_wrap_dout", 32'(j_d_out), 32'h1A5);

      // Five wait cycles: strobe held six cycles
      s0 = strobe_total;
      bus.d_ramwait = 1'b1;
      bus.d_dm_dbusin = 8'h3C;
      push_exp(0, 0, 16'h0050, 8'h00);
      pulse_ac(ac_word(0, 0, 0, 4'd0, 16'h0050));
      for (int n = 0; n < 50 && (strobe_total - s0) < 5; n++) begin
         @(negedge cp2);
         #1;
      end
      @(posedge cp2);
      #1;
      bus.d_ramwait = 1'b0;
      wait_idle("wait_idle", 20);
      check_eq("wait_strobes", strobe_total - s0, 6);
      check_eq("wait_dout", 32'(j_d_out), 32'h13C);
      check_eq("wait_no_err", 32'(j_ac_out[AC_W-2]), 0);

      // Stuck wait: timeout after 15 cycles, remaining kept
      s0 = strobe_total;
      bus.d_iowait = 1'b1;
      pulse_ac(ac_word(0, 1, 1, 4'd2, 16'h0010));
      wait_idle("to_idle", 40);
      check_eq("to_strobes", strobe_total - s0, 15);
      check_eq("to_acout", 32'(j_ac_out), 32'({1'b0, 1'b1, 1'b0, 4'd2, 16'h0010}));
      bus.d_iowait = 1'b0;

      // d_e during ACC sets ovf; access unaffected; new command cleared to_err
      bus.d_ramwait = 1'b1;
      bus.d_dm_dbusin = 8'hC3;
      push_exp(0, 0, 16'h0200, 8'h00);
      pulse_ac(ac_word(0, 0, 0, 4'd0, 16'h0200));
      pulse_d(8'h00);
      @(posedge cp2);
      #1;
      bus.d_ramwait = 1'b0;
      wait_idle("ovf_idle", 20);
      check_eq("ovf_flags", 32'(j_ac_out[AC_W-1:AC_W-3]), 32'b001);
      check_eq("ovf_dout", 32'(j_d_out), 32'h1C3);

      // ac_e while busy sets ovf; tlr_st mid-burst clears everything
      push_exp(0, 1, 16'h0300, 8'h5E);
      pulse_ac(ac_word(1, 0, 1, 4'd3, 16'h0300));
      pulse_d(8'h5E);
      repeat (2) @(negedge cp2);
      pulse_ac(ac_word(0, 1, 0, 4'd0, 16'h0007));
      #1;
      check_eq("busy_ovf_acout", 32'(j_ac_out), 32'({1'b1, 1'b0, 1'b1, 4'd2, 16'h0301}));
      @(negedge cp2);
      tlr_st = 1'b1;
      @(negedge cp2);
      tlr_st = 1'b0;
      #1;
      check_eq("tlr_flags", 32'(j_ac_out[AC_W-1:AC_W-3]), 0);
      check_eq("tlr_rd_valid", 32'(j_d_out[DW]), 0);
      s0 = strobe_total;
      pulse_d(8'hEE);
      repeat (3) @(negedge cp2);
      #1;
      check_eq("tlr_no_access", strobe_total - s0, 0);

      // Simultaneous ac_e and d_e in IDLE: command taken, d_e dropped
      @(negedge cp2);
      j_ac_in = ac_word(1, 0, 0, 4'd0, 16'h0400);
      j_d_in  = 8'hEE;
      j_upd_ac = 1'b1;
      j_upd_d  = 1'b1;
      @(negedge cp2);
      j_upd_ac = 1'b0;
      j_upd_d  = 1'b0;
      repeat (2) @(negedge cp2);
      #1;
      check_eq("simul_state", 32'(j_ac_out[AC_W-1:AC_W-3]), 32'b100);
      push_exp(0, 1, 16'h0400, 8'h99);
      pulse_d(8'h99);
      wait_idle("simul_idle", 20);
      check_eq("simul_ovf", 32'(j_ac_out[AC_W-3]), 0);

      check_eq("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
